// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between NUM_REQ producers and the round-robin arbiter.
// Latency: none, wires only.
// Backpressure: out_ready_i flows from the consumer back into the arbiter.
// Ports: req_i/data_i/last_i are the per-lane request side, packed lane-major.
//        gnt_o is the one-hot grant, out_* is the merged channel, busy_o shows an open burst.
interface rr_mux_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        last_i;
  logic                      out_ready_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      out_valid_o;
  logic [DATA_W-1:0]         out_data_o;
  logic                      out_last_o;
  logic                      busy_o;

  // Arbiter side.
  modport slave (
    input  req_i, data_i, last_i, out_ready_i,
    output gnt_o, out_valid_o, out_data_o, out_last_o, busy_o
  );

  // Producer/consumer side.
  modport master (
    output req_i, data_i, last_i, out_ready_i,
    input  gnt_o, out_valid_o, out_data_o, out_last_o, busy_o
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin burst arbiter driving a one-hot and-or mux onto one shared output channel.
// Latency: 1 cycle from request to grant, then data/last pass through combinationally; 1 idle cycle between bursts.
// Backpressure: out_ready_i=0 freezes grant, pointer and state; the held lane simply waits.
// Ports: clk, reset (sync, active-high), bus (slave modport of rr_mux_arbiter_if).
module rr_mux_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  rr_mux_arbiter_if.slave    bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;   // index of the granted lane, avoids re-encoding gnt_q
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;
  logic [DATA_W-1:0]  mux_data;
  logic               mux_last;
  logic               out_valid;
  logic               xfer_last;

  // (base + off) mod NUM_REQ; both operands are below NUM_REQ so one subtract suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PTR_W-1:0];
  endfunction

  // First requesting lane at or after the rotating pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && bus.req_i[wrap_add(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // And-or mux: an all-zero grant yields zero data and last.
  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mux_data = mux_data | (bus.data_i[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i]}});
      mux_last = mux_last | (bus.last_i[i] & gnt_q[i]);
    end
  end

  assign out_valid = (state_q == GRANT) & bus.req_i[gidx_q];
  assign xfer_last = out_valid & bus.out_ready_i & mux_last;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gidx_d          = pick_idx;
        end
      end
      GRANT: begin
        // Releasing lane drops to lowest priority for the next round.
        if (xfer_last) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = wrap_add(gidx_q, 1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = mux_data;
  assign bus.out_last_o  = mux_last;
  assign bus.busy_o      = (state_q == GRANT);

  gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
  busy_match: assert property (@(posedge clk) disable iff (reset) (state_q == GRANT) == (|gnt_q));
  gnt_hold:   assert property (@(posedge clk) disable iff (reset)
                               (state_q == GRANT && !xfer_last) |=> $stable(gnt_q));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rr_mux_arbiter_if #(.NUM_REQ(4), .DATA_W(8))  bus4 ();
  rr_mux_arbiter_if #(.NUM_REQ(2), .DATA_W(16)) bus2 ();

  rr_mux_arbiter #(.NUM_REQ(4), .DATA_W(8)) u4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  rr_mux_arbiter #(.NUM_REQ(2), .DATA_W(16)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus4.req_i = '0; bus4.data_i = '0; bus4.last_i = '0; bus4.out_ready_i = 1'b0;
    bus2.req_i = '0; bus2.data_i = '0; bus2.last_i = '0; bus2.out_ready_i = 1'b0;

    // Reset state
    nxt; #1;
    chk("rst_gnt",   32'(bus4.gnt_o), 32'h0);
    chk("rst_busy",  32'(bus4.busy_o), 32'h0);
    chk("rst_valid", 32'(bus4.out_valid_o), 32'h0);
    chk("rst_gnt2",  32'(bus2.gnt_o), 32'h0);
    reset = 1'b0;

    // Idle, no requests
    for (int c = 0; c < 5; c++) begin
      nxt; #1;
      chk("idle_gnt",   32'(bus4.gnt_o), 32'h0);
      chk("idle_valid", 32'(bus4.out_valid_o), 32'h0);
      chk("idle_busy",  32'(bus4.busy_o), 32'h0);
    end

    // All lanes requesting single-beat bursts: 0001,0010,0100,1000,0001 with idle gaps
    bus4.req_i = 4'b1111; bus4.last_i = 4'b1111; bus4.out_ready_i = 1'b1;
    bus4.data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 5; k++) begin
      nxt; #1;
      chk("rot_gnt",   32'(bus4.gnt_o), 32'h1 << (k % 4));
      chk("rot_data",  32'(bus4.out_data_o), 32'hA0 + 32'(k % 4));
      chk("rot_valid", 32'(bus4.out_valid_o), 32'h1);
      nxt; #1;
      chk("rot_gap_gnt",  32'(bus4.gnt_o), 32'h0);
      chk("rot_gap_busy", 32'(bus4.busy_o), 32'h0);
      chk("rot_gap_data", 32'(bus4.out_data_o), 32'h0);
    end

    // ptr=1 now; lanes 0,2,3 request, lane 2 wins with a 3-beat burst and a 2-cycle stall
    bus4.req_i = 4'b1101; bus4.last_i = 4'b0000;
    bus4.data_i = {8'h33, 8'h21, 8'h11, 8'h01};
    nxt; bus4.last_i = 4'b1001; #1;
    chk("b3_gnt1",  32'(bus4.gnt_o), 32'h4);
    chk("b3_val1",  32'(bus4.out_valid_o), 32'h1);
    chk("b3_dat1",  32'(bus4.out_data_o), 32'h21);
    chk("b3_last1", 32'(bus4.out_last_o), 32'h0);
    nxt; bus4.data_i = {8'h33, 8'h22, 8'h11, 8'h01}; bus4.out_ready_i = 1'b0; #1;
    chk("b3_stall1_gnt", 32'(bus4.gnt_o), 32'h4);
    chk("b3_stall1_dat", 32'(bus4.out_data_o), 32'h22);
    nxt; #1;
    chk("b3_stall2_gnt",  32'(bus4.gnt_o), 32'h4);
    chk("b3_stall2_busy", 32'(bus4.busy_o), 32'h1);
    nxt; bus4.out_ready_i = 1'b1; #1;
    chk("b3_gnt2", 32'(bus4.gnt_o), 32'h4);
    chk("b3_val2", 32'(bus4.out_valid_o), 32'h1);
    nxt; bus4.data_i = {8'h33, 8'h23, 8'h11, 8'h01}; bus4.last_i = 4'b1101; #1;
    chk("b3_gnt3",  32'(bus4.gnt_o), 32'h4);
    chk("b3_last3", 32'(bus4.out_last_o), 32'h1);
    chk("b3_dat3",  32'(bus4.out_data_o), 32'h23);
    nxt; bus4.req_i = 4'b1001; bus4.last_i = 4'b0000; #1;
    chk("b3_gap_gnt",  32'(bus4.gnt_o), 32'h0);
    chk("b3_gap_busy", 32'(bus4.busy_o), 32'h0);
    nxt; bus4.last_i = 4'b1000; #1;
    chk("b3_next_gnt", 32'(bus4.gnt_o), 32'h8);
    chk("b3_next_dat", 32'(bus4.out_data_o), 32'h33);

    // ptr=0: single beat on lane 0 moves ptr to 1
    nxt; bus4.req_i = 4'b0001; bus4.last_i = 4'b0001; #1;
    chk("pre_gap_gnt", 32'(bus4.gnt_o), 32'h0);
    nxt; #1;
    chk("pre_gnt0", 32'(bus4.gnt_o), 32'h1);
    nxt; bus4.req_i = 4'b0011; bus4.last_i = 4'b0000; #1;
    chk("pre_gap2_gnt", 32'(bus4.gnt_o), 32'h0);

    // Lane 1 granted, drops req for 3 cycles while lane 0 waits
    nxt; #1;
    chk("hole_gnt_b1", 32'(bus4.gnt_o), 32'h2);
    chk("hole_val_b1", 32'(bus4.out_valid_o), 32'h1);
    chk("hole_dat_b1", 32'(bus4.out_data_o), 32'h11);
    for (int c = 0; c < 3; c++) begin
      nxt; bus4.req_i = 4'b0001; #1;
      chk("hole_gnt",  32'(bus4.gnt_o), 32'h2);
      chk("hole_val",  32'(bus4.out_valid_o), 32'h0);
      chk("hole_busy", 32'(bus4.busy_o), 32'h1);
    end
    nxt; bus4.req_i = 4'b0011; bus4.last_i = 4'b0010; bus4.data_i = {8'h33, 8'h23, 8'h12, 8'h01}; #1;
    chk("hole_gnt_end",  32'(bus4.gnt_o), 32'h2);
    chk("hole_val_end",  32'(bus4.out_valid_o), 32'h1);
    chk("hole_last_end", 32'(bus4.out_last_o), 32'h1);
    chk("hole_dat_end",  32'(bus4.out_data_o), 32'h12);
    nxt; bus4.req_i = 4'b0001; bus4.last_i = 4'b0000; #1;
    chk("hole_gap_gnt", 32'(bus4.gnt_o), 32'h0);
    nxt; bus4.last_i = 4'b0001; #1;
    chk("hole_lane0_gnt", 32'(bus4.gnt_o), 32'h1);
    chk("hole_lane0_dat", 32'(bus4.out_data_o), 32'h01);

    // ptr=1: lane 3 burst, reset mid-burst, then lane 0 wins from ptr=0
    nxt; bus4.req_i = 4'b1000; bus4.last_i = 4'b0000; #1;
    chk("rb_gap_gnt", 32'(bus4.gnt_o), 32'h0);
    nxt; #1;
    chk("rb_gnt3", 32'(bus4.gnt_o), 32'h8);
    chk("rb_val3", 32'(bus4.out_valid_o), 32'h1);
    nxt; reset = 1'b1; bus4.req_i = 4'b1001; #1;
    chk("rb_pre_gnt", 32'(bus4.gnt_o), 32'h8);
    nxt; reset = 1'b0; #1;
    chk("rb_gnt",   32'(bus4.gnt_o), 32'h0);
    chk("rb_busy",  32'(bus4.busy_o), 32'h0);
    chk("rb_valid", 32'(bus4.out_valid_o), 32'h0);
    chk("rb_data",  32'(bus4.out_data_o), 32'h0);
    chk("rb_last",  32'(bus4.out_last_o), 32'h0);
    nxt; bus4.req_i = 4'b0000; #1;
    chk("rb_after_gnt",  32'(bus4.gnt_o), 32'h1);
    chk("rb_after_busy", 32'(bus4.busy_o), 32'h1);

    // Two-lane, 16-bit instance: strict alternation of single-beat bursts
    nxt; bus2.req_i = 2'b11; bus2.last_i = 2'b11; bus2.out_ready_i = 1'b1;
    bus2.data_i = {16'hBEEF, 16'h1234}; #1;
    chk("n2_idle_gnt", 32'(bus2.gnt_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      nxt; #1;
      chk("n2_gnt",   32'(bus2.gnt_o), 32'h1 << (k % 2));
      chk("n2_data",  32'(bus2.out_data_o), (k % 2 == 1) ? 32'hBEEF : 32'h1234);
      chk("n2_valid", 32'(bus2.out_valid_o), 32'h1);
      nxt; #1;
      chk("n2_gap_gnt",  32'(bus2.gnt_o), 32'h0);
      chk("n2_gap_data", 32'(bus2.out_data_o), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that owns a shared one-hot-select mux and shares one output channel between NUM_REQ requesters.
- Produces the one-hot select from a registered grant. Holds the grant for a whole burst, terminated by last. Forwards the selected requester's data through an and-or mux.
- Sits upstream of any single-consumer resource that several producers must share.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 8, data width per requester.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester valid/request; bit i belongs to requester i.
- data_i  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- last_i  input  NUM_REQ  per-requester end-of-burst marker, qualified by req_i.
- gnt_o  output  NUM_REQ  registered one-hot grant (mux select); all-zero when idle.
- out_valid_o  output  1  req_i[g] & (state==GRANT), where g is the granted index.
- out_data_o  output  DATA_W  and-or mux of data_i under gnt_o; 0 when gnt_o==0.
- out_last_o  output  1  and-or mux of last_i under gnt_o; 0 when gnt_o==0.
- out_ready_i  input  1  downstream accepts the beat.
- busy_o  output  1  1 while in GRANT.

Behaviour:
- State machine has two states:
  - IDLE: gnt_o=0.
  - GRANT: gnt_o one-hot, held constant.
- Rotating priority pointer ptr has width clog2(NUM_REQ).
- Reset (synchronous, checked every edge, overrides everything including mid-burst):
  - state=IDLE, gnt_o=0, ptr=0.
  - All outputs read 0 in the cycle after reset is sampled high.
  - No partial burst resumes after reset.
- IDLE, no request (req_i==0): stay in IDLE, ptr unchanged.
- IDLE, any req_i bit set:
  - Select the first set bit searching ptr, ptr+1, … wrapping mod NUM_REQ.
  - Next cycle: gnt_o=one-hot(g), state=GRANT.
  - Grant latency is 1 cycle from request sampled to gnt_o.
- GRANT, beat transfer:
  - A beat transfers when out_valid_o & out_ready_i.
  - Data and last are combinational pass-through of the granted lane; no added latency.
- GRANT, granted requester drops req_i:
  - Grant is held and out_valid_o=0.
  - Requests from other lanes are ignored until release.
- GRANT, release:
  - A transfer with out_last_o=1 releases the grant.
  - Next cycle: state=IDLE, gnt_o=0, ptr=(g+1) mod NUM_REQ.
  - This gives a mandatory one-cycle IDLE bubble between bursts; re-arbitration happens in that IDLE cycle.
- Simultaneous requests:
  - Only ptr ordering decides the winner.
  - A requester that just released has lowest priority next round.
- Single-beat burst: req and last high together at transfer → release after one beat.
- last_i on non-granted lanes, or while out_ready_i=0, has no effect.
- Back-pressure: out_ready_i=0 stalls indefinitely; grant, ptr and state are unchanged.
- Invariants (for assertions):
  - gnt_o is always one-hot or zero.
  - gnt_o changes only on the IDLE→GRANT and GRANT→IDLE transitions.
  - busy_o == |gnt_o.

Test Plan:
- Reset, then req_i=4'b0000 for 5 cycles → gnt_o=0, out_valid_o=0, busy_o=0 throughout.
- req_i=4'b1111 constantly, last_i=4'b1111, out_ready_i=1 → grants cycle 0001, 0010, 0100, 1000, 0001, with an IDLE cycle between each; out_data_o equals the granted lane's data.
- Lane 2 holds a 3-beat burst (last on beat 3) while lanes 0 and 3 request; out_ready_i=0 on beat 2 for 2 cycles → gnt_o=0100 held for all 3 transfers plus 2 stall cycles; next grant is 1000 (ptr=3).
- Lane 1 granted, drops req_i for 3 cycles mid-burst while lane 0 requests → gnt_o stays 0010 and out_valid_o=0 during the gap; lane 0 is granted only after lane 1's last beat.
- Assert reset during a burst on lane 3 → next cycle gnt_o=0, busy_o=0; with req_i=4'b1001 afterwards, lane 0 wins (ptr reset to 0).
- NUM_REQ=2, DATA_W=16: alternating single-beat requests on both lanes → strict alternation 01, 10, 01; out_data_o matches data_i slices bit-exactly.
